// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the vga_adapter write port: one requester draws a whole shape at a time,
// its pixel stream is registered onto the adapter, and a watchdog reclaims a hung grant.
module vga_plot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 3125000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     rel,
  input  logic [NUM_REQ*8-1:0]   req_x,
  input  logic [NUM_REQ*7-1:0]   req_y,
  input  logic [NUM_REQ*3-1:0]   req_colour,
  input  logic [NUM_REQ-1:0]     req_plot,
  output logic [NUM_REQ-1:0]     grant,
  output logic [IDX_W-1:0]       owner,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  localparam logic [21:0]      TMO_LAST = 22'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [21:0]         r_timer;
  logic [7:0]          r_x;
  logic [6:0]          r_y;
  logic [2:0]          r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_terr;

  // Per-requester views of the packed coordinate buses.
  logic [NUM_REQ-1:0][7:0] w_x_arr;
  logic [NUM_REQ-1:0][6:0] w_y_arr;
  logic [NUM_REQ-1:0][2:0] w_c_arr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_x_arr[i] = req_x[8*i +: 8];
    assign w_y_arr[i] = req_y[7*i +: 7];
    assign w_c_arr[i] = req_colour[3*i +: 3];
  end

  // Rotate req so bit 0 is rr_ptr; the lowest set bit is the offset of the winner.
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W:0]       w_wrap;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_any;

  assign w_dbl = {req, req} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];
  assign w_any = |req;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_wrap = w_sum - NREQ_W;
  assign w_sel  = (w_sum >= NREQ_W) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];

  logic [NUM_REQ-1:0] w_sel_oh;
  assign w_sel_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

  logic             w_tmo;
  logic             w_vol;
  logic [IDX_W-1:0] w_ptr_nxt;

  assign w_tmo     = (r_timer == TMO_LAST);
  assign w_vol     = rel[r_owner] | ~req[r_owner];
  assign w_ptr_nxt = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_timer  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_plot <= 1'b0;
          if (w_any) begin
            r_state <= OWN;
            r_grant <= w_sel_oh;
            r_owner <= w_sel;
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end
        OWN: begin
          r_x      <= w_x_arr[r_owner];
          r_y      <= w_y_arr[r_owner];
          r_colour <= w_c_arr[r_owner];
          if (w_vol || w_tmo) begin
            // The pixel presented on the release cycle is dropped on purpose.
            r_state  <= GAP;
            r_grant  <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_ptr_nxt;
            r_terr   <= w_tmo & ~w_vol;
          end else begin
            r_plot  <= req_plot[r_owner];
            r_timer <= r_timer + 22'd1;
          end
        end
        GAP: begin
          r_plot  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign owner       = r_owner;
  assign x           = r_x;
  assign y           = r_y;
  assign colour      = r_colour;
  assign plot        = r_plot;
  assign busy        = r_busy;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed scenarios plus random traffic against a cycle-level reference of the arbiter rules.
module tb_vga_plot_arbiter;
  localparam int NR  = 4;
  localparam int IW  = 2;
  localparam int TMO = 20;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req = '0, rel = '0, req_plot = '0;
  logic [NR*8-1:0] req_x = '0;
  logic [NR*7-1:0] req_y = '0;
  logic [NR*3-1:0] req_colour = '0;
  logic [NR-1:0]   grant;
  logic [IW-1:0]   owner;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [2:0]      colour;
  logic            plot, busy, timeout_err;

  vga_plot_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rel(rel),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
    .grant(grant), .owner(owner), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Reference: m_own = current owner or -1, m_gap = dead cycle pending, m_cnt = cycles owned so far.
  int         m_own = -1, m_gap = 0, m_ptr = 0, m_owner = 0, m_cnt = 0;
  logic [7:0] m_x = '0;
  logic [6:0] m_y = '0;
  logic [2:0] m_c = '0;
  logic       m_plot = 1'b0, m_terr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    bit to, vol, found;
    if (!reset_n) begin
      m_own = -1; m_gap = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_terr = 1'b0;
    end else begin
      m_plot = 1'b0;
      m_terr = 1'b0;
      if (m_own >= 0) begin
        m_x = req_x[m_own*8 +: 8];
        m_y = req_y[m_own*7 +: 7];
        m_c = req_colour[m_own*3 +: 3];
        to  = (m_cnt == TMO - 1);
        vol = rel[m_own] || !req[m_own];
        if (to || vol) begin
          m_terr = to && !vol;
          m_ptr  = (m_own + 1) % NR;
          m_own  = -1;
          m_gap  = 1;
        end else begin
          m_plot = req_plot[m_own];
          m_cnt++;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          if (!found && req[(m_ptr + k) % NR]) begin
            found   = 1;
            m_own   = (m_ptr + k) % NR;
            m_owner = m_own;
            m_cnt   = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [31:0] eg;
    eg = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
    chk("grant",  32'(grant), eg);
    chk("owner",  32'(owner), 32'(m_owner));
    chk("x",      32'(x), 32'(m_x));
    chk("y",      32'(y), 32'(m_y));
    chk("colour", 32'(colour), 32'(m_c));
    chk("plot",   32'(plot), 32'(m_plot));
    chk("busy",   32'(busy), (m_own >= 0) ? 32'd1 : 32'd0);
    chk("terr",   32'(timeout_err), 32'(m_terr));
    chk("onehot", ($countones(grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
    chk("plot_busy", (plot && !busy) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic quiesce();
    req = '0; rel = '0; req_plot = '0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; rel = '0; req_plot = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  int ord[5] = '{1, 2, 4, 8, 1};

  initial begin
    int         n;
    bit         hit;
    logic [NR-1:0] prev;

    // A: single requester draws three pixels then releases.
    do_reset();
    req = 4'b0001; req_x[7:0] = 8'd79; req_y[6:0] = 7'd63; req_colour[2:0] = 3'b100;
    tick();
    chk("A_grant", 32'(grant), 32'h1);
    req_plot[0] = 1'b1;
    repeat (3) tick();
    chk("A_x", 32'(x), 32'd79);
    chk("A_plot", 32'(plot), 32'd1);
    req_plot[0] = 1'b0; rel[0] = 1'b1;
    tick();
    rel = '0; req = '0;
    repeat (3) tick();

    // B: all request, each owner releases on its fifth cycle.
    do_reset();
    req = 4'b1111; n = 0; prev = '0;
    repeat (45) begin
      rel = '0;
      if (m_own >= 0 && m_cnt == 4) rel[m_own] = 1'b1;
      tick();
      if (grant != 0 && prev == 0 && n < 5) begin
        chk("B_order", 32'(grant), 32'(ord[n]));
        n++;
      end
      prev = grant;
    end
    chk("B_count", 32'(n), 32'd5);
    quiesce();

    // C: owner 2 active while requester 1 strobes x=10.
    req = 4'b0100;
    repeat (4) tick();
    req[1] = 1'b1; req_plot[1] = 1'b1; req_x[15:8] = 8'd10; req_x[23:16] = 8'd50;
    repeat (8) begin
      req_plot[2] = 1'($urandom_range(0, 1));
      tick();
      chk("C_nonown", (plot && x == 8'd10) ? 32'd1 : 32'd0, 32'd0);
    end
    rel[2] = 1'b1; req[1] = 1'b0;
    tick();
    quiesce();

    // D: two requesters never release; watchdog rotates them.
    req = 4'b0011; n = 0;
    repeat (80) begin
      req_plot = 4'($urandom);
      tick();
      if (timeout_err) n++;
    end
    chk("D_tmo_seen", (n >= 2) ? 32'd1 : 32'd0, 32'd1);
    quiesce();

    // E: rel on the timeout cycle is a normal release.
    req = 4'b0001;
    repeat (60) begin
      rel = '0;
      if (m_own == 0 && m_cnt == TMO - 1) rel[0] = 1'b1;
      tick();
      chk("E_noerr", 32'(timeout_err), 32'd0);
    end
    quiesce();

    // F: owner drops req mid-shape; in-flight pixel is dropped.
    req = 4'b0010; req_plot = 4'b0010;
    hit = 0;
    repeat (10) begin
      if (m_own == 1 && m_cnt == 3) begin req[1] = 1'b0; hit = 1; end
      tick();
    end
    chk("F_reach", 32'(hit), 32'd1);
    quiesce();

    // G: reset while owning with plot high, then rr search from 0.
    req = 4'b1000; req_plot = 4'b1000;
    hit = 0;
    repeat (10) if (!hit) begin
      tick();
      if (m_own == 3 && m_cnt >= 2) hit = 1;
    end
    chk("G_reach", 32'(hit), 32'd1);
    reset_n = 1'b0; req = '0; req_plot = '0;
    tick();
    chk("G_rst_plot", 32'(plot), 32'd0);
    chk("G_rst_grant", 32'(grant), 32'd0);
    reset_n = 1'b1; req = 4'b0100;
    tick();
    chk("G_rr", 32'(grant), 32'h4);
    quiesce();

    // Random traffic.
    repeat (1500) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 24) == 0) req[i] = 1'b0;
        rel[i] = ($urandom_range(0, 15) == 0);
      end
      req_plot   = 4'($urandom);
      req_x      = 32'($urandom);
      req_y      = 28'($urandom);
      req_colour = 12'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
